// File: rtl/fifo8x9_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo8x9_ctrl_if: request/status and storage-strobe bundle for the FIFO   |
// | control stage.                                        Revision: 1.0      |
// +--------------------------------------------------------------------------+
interface fifo8x9_ctrl_if #(
  parameter int CNT_W = 4
) ();
  logic             push;
  logic             pop;
  logic             flush;
  logic             wren;
  logic             WrInc;
  logic             WrPtrClr;
  logic             rden;
  logic             RdInc;
  logic             RdPtrClr;
  logic             in_ready;
  logic             out_avail;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             rd_valid;
  logic             overflow;
  logic             underflow;

  // Requester / storage side.
  modport master (
    output push, pop, flush,
    input  wren, WrInc, WrPtrClr, rden, RdInc, RdPtrClr,
    input  in_ready, out_avail, full, empty, count,
    input  rd_valid, overflow, underflow
  );

  // Controller side.
  modport slave (
    input  push, pop, flush,
    output wren, WrInc, WrPtrClr, rden, RdInc, RdPtrClr,
    output in_ready, out_avail, full, empty, count,
    output rd_valid, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/fifo8x9_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo8x9_ctrl: push/pop to storage-strobe converter with occupancy,      |
// | sticky error flags and a one-cycle flush sequence.    Revision: 1.0      |
// +--------------------------------------------------------------------------+
module fifo8x9_ctrl #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  wire            clk,
  input  wire            rst,
  fifo8x9_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_FLUSH  = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_rd_valid;
  logic             r_overflow;
  logic             r_underflow;

  logic w_normal;
  logic w_full;
  logic w_empty;
  logic w_acc_wr;
  logic w_acc_rd;

  assign w_normal = (r_state == ST_NORMAL);
  assign w_full   = (r_count == c_depth);
  assign w_empty  = (r_count == '0);
  assign w_acc_wr = bus.push & ~w_full  & w_normal;
  assign w_acc_rd = bus.pop  & ~w_empty & w_normal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_NORMAL;
      r_count     <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      case (r_state)
        ST_NORMAL: begin
          // Transfers in this cycle complete even when a flush is requested.
          if (bus.flush) r_state <= ST_FLUSH;
          if (w_acc_wr && !w_acc_rd)      r_count <= r_count + c_one;
          else if (w_acc_rd && !w_acc_wr) r_count <= r_count - c_one;
          r_rd_valid <= w_acc_rd;
          if (bus.push && w_full)  r_overflow  <= 1'b1;
          if (bus.pop  && w_empty) r_underflow <= 1'b1;
        end
        ST_FLUSH: begin
          r_state     <= ST_NORMAL;
          r_count     <= '0;
          r_rd_valid  <= 1'b0;
          r_overflow  <= 1'b0;
          r_underflow <= 1'b0;
        end
        default: r_state <= ST_NORMAL;
      endcase
    end
  end

  assign bus.wren      = w_acc_wr;
  assign bus.WrInc     = w_acc_wr;
  assign bus.WrPtrClr  = ~w_normal;
  assign bus.rden      = w_acc_rd;
  assign bus.RdInc     = w_acc_rd;
  assign bus.RdPtrClr  = ~w_normal;
  assign bus.in_ready  = ~w_full  & w_normal;
  assign bus.out_avail = ~w_empty & w_normal;
  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
  assign bus.count     = r_count;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo8x9_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fifo8x9_ctrl: directed + random bench against a queue-based model,    |
// | with a small storage model driven by the DUT strobes. Revision: 1.0      |
// +--------------------------------------------------------------------------+
module tb_fifo8x9_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo8x9_ctrl_if #(.CNT_W(4)) bus ();
  fifo8x9_ctrl #(.DEPTH(8), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_total = 0;
  int n_bad   = 0;

  // Storage block model, driven only by the DUT strobes.
  logic [8:0] din;
  logic [8:0] mem [8];
  logic [2:0] wptr, rptr;
  logic [8:0] sdout;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0; rptr <= '0; sdout <= '0;
    end else begin
      if (bus.wren) mem[wptr] <= din;
      if (bus.rden) sdout <= mem[rptr];
      if (bus.WrPtrClr) wptr <= '0; else if (bus.WrInc) wptr <= wptr + 3'd1;
      if (bus.RdPtrClr) rptr <= '0; else if (bus.RdInc) rptr <= rptr + 3'd1;
    end
  end

  // Reference model: FIFO contents as a queue plus a few flags.
  logic [8:0] q [$];
  bit         m_flush, m_rdv, m_ovf, m_udf;
  logic [8:0] m_dout;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_flush = 0; m_rdv = 0; m_ovf = 0; m_udf = 0;
  endtask

  // Called at posedge+1; checks at negedge, advances the model at posedge.
  task automatic step(input bit p, input bit o, input bit f, input logic [8:0] d);
    bit normal, full, empty, awr, ard;
    bus.push = p; bus.pop = o; bus.flush = f; din = d;
    normal = !m_flush;
    full   = (q.size() == 8);
    empty  = (q.size() == 0);
    awr    = p && !full && normal;
    ard    = o && !empty && normal;
    @(negedge clk);
    chk("strobes", {26'd0, bus.wren, bus.WrInc, bus.WrPtrClr, bus.rden, bus.RdInc, bus.RdPtrClr},
        {26'd0, awr, awr, !normal, ard, ard, !normal});
    chk("status", {25'd0, bus.in_ready, bus.out_avail, bus.full, bus.empty, bus.rd_valid, bus.overflow, bus.underflow},
        {25'd0, !full && normal, !empty && normal, full, empty, m_rdv, m_ovf, m_udf});
    chk("count", 32'(bus.count), q.size());
    if (m_rdv) chk("dataout", 32'(sdout), 32'(m_dout));
    @(posedge clk);
    if (!normal) begin
      q.delete(); m_ovf = 0; m_udf = 0; m_rdv = 0; m_flush = 0;
    end else begin
      if (p && full)  m_ovf = 1;
      if (o && empty) m_udf = 1;
      m_rdv = ard;
      if (ard) m_dout = q.pop_front();
      if (awr) q.push_back(d);
      m_flush = f;
    end
    #1;
  endtask

  initial begin
    bus.push = 0; bus.pop = 0; bus.flush = 0; din = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    repeat (3) step(0, 0, 0, 9'h0);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 9'h101 + 9'(i));
    for (int i = 0; i < 9; i++) step(0, 1, 0, 9'h0);
    step(0, 0, 0, 9'h0);

    // Simultaneous traffic at mid, full and empty occupancy.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 9'h020 + 9'(i));
    for (int i = 0; i < 5; i++) step(1, 1, 0, 9'h030 + 9'(i));
    for (int i = 0; i < 5; i++) step(1, 0, 0, 9'h040 + 9'(i));
    step(1, 1, 0, 9'h050);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 9'h0);
    step(1, 1, 0, 9'h060);

    // Flush with overflow pending and a concurrent push.
    for (int i = 0; i < 8; i++) step(1, 0, 0, 9'h070 + 9'(i));
    for (int i = 0; i < 3; i++) step(0, 1, 0, 9'h0);
    step(1, 0, 1, 9'h0F0);
    step(1, 0, 0, 9'h0F1);
    step(0, 0, 0, 9'h0);
    step(1, 0, 0, 9'h1AA);
    step(0, 1, 0, 9'h0);
    step(0, 0, 0, 9'h0);

    // Asynchronous reset mid-burst: count=4, rd_valid=1.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 9'h080 + 9'(i));
    step(0, 1, 0, 9'h0);
    bus.push = 0; bus.pop = 0; bus.flush = 0;
    #2 rst = 1'b1;
    #1;
    chk("rst_strobes", {26'd0, bus.wren, bus.WrInc, bus.WrPtrClr, bus.rden, bus.RdInc, bus.RdPtrClr}, 32'd0);
    chk("rst_status", {25'd0, bus.in_ready, bus.out_avail, bus.full, bus.empty, bus.rd_valid, bus.overflow, bus.underflow},
        32'b1001000);
    chk("rst_count", 32'(bus.count), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) < 3, 9'($urandom));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo8x9_ctrl.md
Name: fifo8x9_ctrl

Overview:
Control stage sitting directly upstream of the 8-deep x 9-bit FIFO storage block. It converts a simple push/pop request interface into the storage block's wren/WrInc/WrPtrClr and rden/RdInc/RdPtrClr strobes. It tracks occupancy, full and empty, read-data validity, and sticky error flags. It also sequences a synchronous flush. The 9-bit data path does not pass through this block; it goes straight to the storage block's DataIn/DataOut.

Parameters:
DEPTH, 8, number of FIFO entries; must match the storage block.
CNT_W, 4, width of the occupancy counter; holds 0..DEPTH.

Ports:
clk  input  1  system clock, all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
push  input  1  write request for this cycle; DataIn is presented to the storage block in the same cycle
pop  input  1  read request for this cycle
flush  input  1  request to empty the FIFO; single-cycle pulse or level
wren  output  1  write enable to storage
WrInc  output  1  write-pointer increment to storage
WrPtrClr  output  1  write-pointer clear to storage
rden  output  1  read enable to storage
RdInc  output  1  read-pointer increment to storage
RdPtrClr  output  1  read-pointer clear to storage
in_ready  output  1  a push in this cycle will be accepted
out_avail  output  1  a pop in this cycle will be accepted
full  output  1  count == DEPTH
empty  output  1  count == 0
count  output  CNT_W  current occupancy
rd_valid  output  1  storage DataOut holds freshly read data this cycle
overflow  output  1  sticky: a push was attempted while full
underflow  output  1  sticky: a pop was attempted while empty

Behaviour:
- Reset (async, rst=1): state=NORMAL, count=0, rd_valid=0, overflow=0, underflow=0. Consequently empty=1, full=0, in_ready=1, out_avail=0, and all strobes are 0.
- States: NORMAL and FLUSH.
  - NORMAL -> FLUSH when flush=1 at a clock edge.
  - FLUSH -> NORMAL unconditionally after one cycle.
  - If flush is held high, the block alternates NORMAL and FLUSH. Every NORMAL cycle between the FLUSH cycles still accepts transfers.
- FLUSH cycle:
  - WrPtrClr=RdPtrClr=1.
  - wren, WrInc, rden, RdInc are 0; push and pop are ignored and not flagged.
  - in_ready=out_avail=0.
  - At the end of the cycle: count becomes 0, and overflow and underflow clear.
- NORMAL cycle: WrPtrClr=RdPtrClr=0.
- Accept conditions (combinational from current state and inputs):
  - acc_wr = push & ~full & (state==NORMAL); wren = WrInc = acc_wr.
  - acc_rd = pop & ~empty & (state==NORMAL); rden = RdInc = acc_rd.
  - in_ready = ~full & NORMAL; out_avail = ~empty & NORMAL.
- Count update at each edge in NORMAL:
  - +1 on acc_wr only.
  - -1 on acc_rd only.
  - Unchanged when both or neither are accepted.
  - Never exceeds DEPTH and never goes below 0.
- Full: push is rejected even when a pop is accepted in the same cycle; the pop proceeds and count drops to DEPTH-1.
- Empty: pop is rejected even when a push is accepted in the same cycle (no fall-through); the push proceeds and count becomes 1.
- Read latency: the storage block registers DataOut on the edge where rden=1. rd_valid is a register loaded with acc_rd, so rd_valid=1 exactly during the cycle after an accepted pop.
- Error flags:
  - overflow sets at the edge where push=1 & full & NORMAL.
  - underflow sets at the edge where pop=1 & empty & NORMAL.
  - Both hold until FLUSH or reset.
- Pointer wrap: the storage pointers wrap modulo DEPTH via their own increment. This block guarantees at most DEPTH un-popped writes, so no entry is overwritten.
- Reset mid-operation: all state returns to reset values immediately. The storage block is expected to share rst, so both blocks restart consistent.

Test Plan:
- Reset, then idle 3 cycles -> count=0, empty=1, full=0, in_ready=1, out_avail=0, all strobes 0, rd_valid=0.
- 8 consecutive pushes with DataIn 0x101..0x108 -> wren pulses 8 times, count steps 1..8, full=1 after the 8th. A 9th push gives wren=0 and overflow=1, and count stays 8.
- From full, 8 consecutive pops -> rden pulses 8 times. rd_valid is high the cycle after each pop, with DataOut 0x101..0x108 in order. empty=1 at the end. A further pop gives rden=0 and underflow=1.
- Count=3, push and pop together for 5 cycles -> wren=rden=1 every cycle and count stays 3. At full, push+pop -> only rden=1 and count=7. At empty, push+pop -> only wren=1 and count=1.
- Count=5 with overflow set, pulse flush one cycle alongside push=1 -> WrPtrClr=RdPtrClr=1 for one cycle, wren=0, then count=0, empty=1, overflow=0. A following push of 0x1AA, then a pop, returns 0x1AA.
- Assert rst mid-burst (count=4, rd_valid=1) -> outputs return to reset values within the same cycle and without a clock edge.
